onchip_mem_stream_loader: RTL and testbench

//  Avalon-MM write/read master placed directly upstream of the 32-bit single-port on-chip RAM
//  (s1 slave, 14-bit word address, 4-bit byteenable, no waitrequest, 1-cycle read latency).

---
 rtl/onchip_mem_stream_loader.sv | 158 +++++++++++++++
 tb/tb_onchip_mem_stream_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_stream_loader.sv
// Packs a byte stream into 32-bit words written to consecutive RAM words, then reads the region back to verify the sum.
// 5 cycles per word with a steady stream; done follows the last write by word_count+2 cycles; bytes are held off outside PACK.
module onchip_mem_stream_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 10000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, PACK, WRITE, VERIFY, FLUSH, CHECK} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            byte_idx;
    logic [23:0]           word;
    logic                  rd_pend;
    logic [31:0]           rd_sum;

    logic [ADDR_WIDTH:0]   end_addr;
    logic                  range_bad;
    logic                  last_word;
    logic [31:0]           rd_sum_nxt;

    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    always_comb begin
        end_addr   = {1'b0, base_addr} + {1'b0, word_count};
        range_bad  = end_addr > DEPTH_W;
        last_word  = (idx == cnt - ONE);
        // Read data lags the address by one cycle, so accumulate on the pending flag.
        rd_sum_nxt = rd_sum + (rd_pend ? mem_readdata : 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            base           <= '0;
            cnt            <= '0;
            idx            <= '0;
            byte_idx       <= '0;
            word           <= '0;
            rd_pend        <= 1'b0;
            rd_sum         <= '0;
            in_ready       <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
        end else begin
            done    <= 1'b0;
            rd_pend <= (state == VERIFY);
            if (rd_pend) rd_sum <= rd_sum_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= base_addr;
                        cnt      <= word_count;
                        idx      <= '0;
                        byte_idx <= '0;
                        checksum <= '0;
                        rd_sum   <= '0;
                        if (word_count == '0) begin
                            done  <= 1'b1;
                            error <= 1'b0;
                        end else if (range_bad) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            error    <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= PACK;
                        end
                    end
                end
                PACK: begin
                    if (in_valid && in_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word[7:0]   <= in_data;
                            2'd1: word[15:8]  <= in_data;
                            2'd2: word[23:16] <= in_data;
                            default: begin
                                in_ready       <= 1'b0;
                                mem_chipselect <= 1'b1;
                                mem_write      <= 1'b1;
                                mem_writedata  <= {in_data, word};
                                mem_address    <= base + idx;
                                state          <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    mem_write <= 1'b0;
                    checksum  <= checksum + mem_writedata;
                    if (last_word) begin
                        idx         <= '0;
                        mem_address <= base;
                        state       <= VERIFY;
                    end else begin
                        idx            <= idx + ONE;
                        mem_chipselect <= 1'b0;
                        in_ready       <= 1'b1;
                        state          <= PACK;
                    end
                end
                VERIFY: begin
                    if (last_word) begin
                        mem_chipselect <= 1'b0;
                        state          <= FLUSH;
                    end else begin
                        idx         <= idx + ONE;
                        mem_address <= mem_address + ONE;
                    end
                end
                FLUSH: begin
                    // Compare against the sum including the final read so done lands in CHECK.
                    error <= error | (rd_sum_nxt != checksum);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= CHECK;
                end
                CHECK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Bench for onchip_mem_stream_loader: RAM model, byte source, and a per-cycle monitor against an operation-level model.
module tb_onchip_mem_stream_loader;
    localparam int AW    = 14;
    localparam int DEPTH = 10000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   checksum;

    onchip_mem_stream_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_due = -1;
    int          nwr = 0;
    int          nrd = 0;
    int          nbytes = 0;
    int          op_base = 0;
    int          op_count = 0;
    int          op_reads = 0;
    int          op_bytes = 0;
    logic [31:0] op_sum = '0;
    logic        op_err = 1'b0;
    logic        op_imm = 1'b0;
    logic        busy_exp = 1'b0;
    logic        err_exp = 1'b0;
    bit          done_seen = 0;
    bit          hs_pending = 0;
    int          gate_pct = 100;
    int          corrupt_addr = -1;
    wr_t         exp_wr_q[$];
    logic [31:0] exp_words[$];
    logic [7:0]  src_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] ram [0:DEPTH-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM with one-cycle read latency; optionally flips bit 0 of one word on the read path.
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
        if (mem_chipselect && !mem_write)
            mem_readdata <= ram[mem_address] ^ ((int'(mem_address) == corrupt_addr) ? 32'h1 : 32'h0);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Byte source: drops a byte only after the handshake seen before the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs_pending && src_q.size() > 0) void'(src_q.pop_front());
            hs_pending = 0;
            if (src_q.size() > 0 && $urandom_range(0, 99) < gate_pct) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit  done_now;
        wr_t w;
        if (reset_n) begin
            hs_pending = in_valid && in_ready;
            done_now = (cyc == done_due);
            if (done_now) err_exp = op_err;
            chk("done", done, done_now);
            chk("busy", busy, busy_exp);
            chk("error", error, err_exp);
            chk("clken", mem_clken, 1);
            chk("byteenable", mem_byteenable, 4'hF);
            if (in_ready) chk("ready_only_packing", busy && !mem_chipselect, 1);
            if (mem_write) chk("write_needs_cs", mem_chipselect, 1);
            if (in_valid && in_ready) nbytes++;
            if (mem_chipselect && mem_write) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", mem_address, w.a);
                    chk("wr_data", mem_writedata, w.d);
                    if (nwr == 0) chk("start_to_write_ge5", (cyc - start_cyc) >= 5, 1);
                    nwr++;
                    if (nwr == op_count) done_due = cyc + op_count + 2;
                end
            end else if (mem_chipselect) begin
                chk("rd_after_all_writes", nwr, op_count);
                chk("rd_addr", mem_address, op_base + nrd);
                nrd++;
            end
            if (done_now) begin
                chk("checksum", checksum, op_sum);
                chk("read_count", nrd, op_reads);
                chk("byte_count", nbytes, op_bytes);
                chk("writes_left", exp_wr_q.size(), 0);
                done_seen = 1;
            end
            if (start && !busy_exp) begin
                start_cyc = cyc;
                nwr = 0;
                nrd = 0;
                nbytes = 0;
                if (op_imm) begin
                    done_due = cyc + 1;
                end else begin
                    busy_exp = 1'b1;
                    err_exp  = 1'b0;
                end
            end
            if (done_due == cyc + 1) busy_exp = 1'b0;
        end
    end

    task automatic launch(input int base, input int count, input int gate, input int corrupt);
        logic [31:0] w;
        op_base  = base;
        op_count = count;
        op_imm   = (count == 0) || (base + count > DEPTH);
        op_err   = (count != 0) && (op_imm || (corrupt >= base && corrupt < base + count));
        op_reads = op_imm ? 0 : count;
        op_bytes = op_reads * 4;
        op_sum   = '0;
        exp_wr_q.delete();
        exp_words.delete();
        if (!op_imm) begin
            for (int j = 0; j < count; j++) begin
                w = {stim_q[4*j+3], stim_q[4*j+2], stim_q[4*j+1], stim_q[4*j]};
                exp_words.push_back(w);
                op_sum += w;
                exp_wr_q.push_back('{AW'(base + j), w});
            end
        end
        corrupt_addr = corrupt;
        gate_pct     = gate;
        done_seen    = 0;
        @(posedge clk);
        #1;
        base_addr  = AW'(base);
        word_count = AW'(count);
        start      = 1'b1;
        if (!op_imm) src_q = stim_q;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done_seen && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        else for (int j = 0; j < exp_words.size(); j++) chk("ram_word", ram[op_base + j], exp_words[j]);
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_byteenable", mem_byteenable, 4'hF);
        chk("rst_chipselect", mem_chipselect, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_writedata", mem_writedata, 0);
        chk("rst_clken", mem_clken, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_checksum", checksum, 0);
    endtask

    initial begin
        int k;
        bit hit;
        #23;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;

        stim_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        launch(0, 1, 100, -1);
        wait_done(200);
        chk("t1_checksum", checksum, 32'h12345678);
        chk("t1_ram0", ram[0], 32'h12345678);
        chk("t1_error", error, 0);

        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'(i));
        launch(9998, 2, 100, -1);
        wait_done(200);
        chk("t2_ram9998", ram[9998], 32'h03020100);
        chk("t2_ram9999", ram[9999], 32'h07060504);
        chk("t2_checksum", checksum, 32'h0A080604);

        stim_q.delete();
        launch(9999, 2, 100, -1);
        wait_done(50);
        chk("t3_range_error", error, 1);
        launch(5, 0, 100, -1);
        wait_done(50);
        chk("t3_zero_error", error, 0);

        fill_random(40);
        launch(9990, 10, 100, -1);
        wait_done(500);

        fill_random(32);
        launch(0, 8, 100, 5);
        wait_done(500);
        repeat (5) @(negedge clk);
        chk("t4_error_sticky", error, 1);

        fill_random(64);
        launch(200, 16, 50, -1);
        repeat (10) @(posedge clk);
        #1;
        base_addr  = AW'(7);
        word_count = AW'(1);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3000);

        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 6);
            fill_random(4 * k);
            launch($urandom_range(0, DEPTH - 10), k, $urandom_range(30, 100), -1);
            wait_done(1000);
        end

        fill_random(32);
        launch(100, 8, 100, -1);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (mem_chipselect && mem_write && mem_address == AW'(103)) hit = 1;
        end
        chk("t6_reached_word3", hit, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        chk_reset_vals();
        src_q.delete();
        in_valid   = 1'b0;
        hs_pending = 0;
        exp_wr_q.delete();
        busy_exp = 1'b0;
        err_exp  = 1'b0;
        done_due = -1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fill_random(16);
        launch(100, 4, 100, -1);
        wait_done(200);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
